// File: rtl/count_seq_monitor.sv
// Continuity checker for a free-running up-counter: confirms each valid sample is
// the previous one plus 1 (mod 2^CNT_W), and reports lock, wraps and breaks in the sequence.
module count_seq_monitor #(
  parameter int CNT_W  = 3,
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clr_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count
);

  // Four bits hold any legal LOCK_N (1..15).
  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [CNT_W-1:0]   exp_cnt;
  logic [RUN_W-1:0]   run_inc;
  logic               match;
  logic               err_det;

  assign exp_cnt = prev_q + CNT_W'(1);
  assign run_inc = run_q + RUN_W'(1);
  assign match   = (cnt_in == exp_cnt);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    locked_d     = locked_q;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    err_det      = 1'b0;

    if (cnt_valid) begin
      unique case (state_q)
        ST_EMPTY: begin
          prev_d  = cnt_in;
          run_d   = '0;
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          prev_d = cnt_in;
          if (match) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_N)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          prev_d = cnt_in;
          if (match) begin
            if (&prev_q) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + WRAP_W'(1);
            end
          end else begin
            // Resync from the offending value; lock must be re-earned.
            err_det  = 1'b1;
            locked_d = 1'b0;
            run_d    = '0;
            state_d  = ST_ACQ;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // A fresh error on the clearing edge takes precedence over the clear.
    if (err_det) begin
      err_pulse_d  = 1'b1;
      err_sticky_d = 1'b1;
      if (clr_err)
        err_count_d = ERR_W'(1);
      else if (!(&err_count_q))
        err_count_d = err_count_q + ERR_W'(1);
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      prev_q       <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor (CNT_W=3, LOCK_N=4), with a LOCK_N=1
// instance on the same stimulus for the single-increment lock case.
module tb_count_seq_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] cnt_in;
  logic       cnt_valid;
  logic       clr_err;

  logic       locked, wrap_pulse, err_pulse, err_sticky;
  logic [7:0] wrap_count;
  logic [3:0] err_count;

  logic       locked1, wrap_pulse1, err_pulse1, err_sticky1;
  logic [7:0] wrap_count1;
  logic [3:0] err_count1;

  int n_pass  = 0;
  int n_total = 0;

  count_seq_monitor #(.CNT_W(3), .LOCK_N(4), .WRAP_W(8), .ERR_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr_err    (clr_err),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  count_seq_monitor #(.CNT_W(3), .LOCK_N(1), .WRAP_W(8), .ERR_W(4)) u_dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .clr_err    (clr_err),
    .locked     (locked1),
    .wrap_pulse (wrap_pulse1),
    .wrap_count (wrap_count1),
    .err_pulse  (err_pulse1),
    .err_sticky (err_sticky1),
    .err_count  (err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic e_locked, input logic e_wp,
                            input logic [7:0] e_wc, input logic e_ep, input logic e_es,
                            input logic [3:0] e_ec);
    check({tag, ".locked"},     32'(locked),     32'(e_locked));
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(e_wp));
    check({tag, ".wrap_count"}, 32'(wrap_count), 32'(e_wc));
    check({tag, ".err_pulse"},  32'(err_pulse),  32'(e_ep));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(e_es));
    check({tag, ".err_count"},  32'(err_count),  32'(e_ec));
  endtask

  // Drive on the falling edge, then observe 1 time unit after the rising edge.
  task automatic step(input logic [2:0] val, input logic vld, input logic clr);
    @(negedge clk);
    cnt_in    = val;
    cnt_valid = vld;
    clr_err   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;
    int         exp_wc;

    rst = 1'b1; cnt_in = '0; cnt_valid = 1'b0; clr_err = 1'b0;
    #2;
    expect_out("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    check("reset.l1_locked", 32'(locked1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: acquire lock on 0..4
    step(3'd0, 1'b1, 1'b0);
    check("t1.s0.locked", 32'(locked), 32'd0);
    check("t1.s0.l1_locked", 32'(locked1), 32'd0);
    step(3'd1, 1'b1, 1'b0);
    check("t1.s1.locked", 32'(locked), 32'd0);
    check("t1.s1.l1_locked", 32'(locked1), 32'd1);
    step(3'd2, 1'b1, 1'b0);
    check("t1.s2.locked", 32'(locked), 32'd0);
    step(3'd3, 1'b1, 1'b0);
    check("t1.s3.locked", 32'(locked), 32'd0);
    step(3'd4, 1'b1, 1'b0);
    expect_out("t1.s4", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);

    // 2: wrap while locked
    step(3'd5, 1'b1, 1'b0);
    step(3'd6, 1'b1, 1'b0);
    step(3'd7, 1'b1, 1'b0);
    expect_out("t2.s7", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    step(3'd0, 1'b1, 1'b0);
    expect_out("t2.s0", 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 4'd0);
    step(3'd1, 1'b1, 1'b0);
    expect_out("t2.s1", 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0);

    // 3: skip 4 -> error, then relock through a wrap that must not count
    step(3'd2, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    step(3'd5, 1'b1, 1'b0);
    expect_out("t3.err", 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 4'd1);
    step(3'd6, 1'b1, 1'b0);
    expect_out("t3.s6", 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 4'd1);
    step(3'd7, 1'b1, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    expect_out("t3.s0", 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 4'd1);
    step(3'd1, 1'b1, 1'b0);
    expect_out("t3.s1", 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 4'd1);

    // 4: gaps with a bogus value do not break continuity
    step(3'd2, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'd6, 1'b0, 1'b0);
      check("t4.gap.err_pulse", 32'(err_pulse), 32'd0);
      check("t4.gap.locked", 32'(locked), 32'd1);
    end
    step(3'd4, 1'b1, 1'b0);
    expect_out("t4.s4", 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 4'd1);

    // 5: error beats clear on the same edge; clear alone; saturation
    step(3'd7, 1'b1, 1'b1);
    expect_out("t5.err_clr", 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 4'd1);
    step(3'd0, 1'b0, 1'b1);
    expect_out("t5.clr", 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0);
    v = 3'd7;
    for (int e = 1; e <= 16; e++) begin
      for (int k = 0; k < 4; k++) begin
        v = v + 3'd1;
        step(v, 1'b1, 1'b0);
      end
      check("t5.relock", 32'(locked), 32'd1);
      v = v + 3'd3;
      step(v, 1'b1, 1'b0);
      check("t5.err_count", 32'(err_count), (e > 15) ? 32'd15 : 32'(e));
    end
    expect_out("t5.sat", 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 4'd15);

    // 6: reach wrap_count=3, then async reset between edges
    for (int k = 0; k < 4; k++) begin
      v = v + 3'd1;
      step(v, 1'b1, 1'b0);
    end
    check("t6.relock", 32'(locked), 32'd1);
    exp_wc = 1;
    for (int k = 0; k < 40 && exp_wc < 3; k++) begin
      if (v == 3'd7) exp_wc++;
      v = v + 3'd1;
      step(v, 1'b1, 1'b0);
    end
    check("t6.wrap_count", 32'(wrap_count), 32'(exp_wc));
    check("t6.wrap_count_is_3", 32'(wrap_count), 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_out("t6.async_rst", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(3'(k), 1'b1, 1'b0);
      check("t6.relock_seq", 32'(locked), (k == 4) ? 32'd1 : 32'd0);
    end
    expect_out("t6.final", 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
